// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Purpose: bundles every signal between the fetch/data requesters, the
// memory-map bus and mem_port_arbiter. Signal names keep the arbiter's
// point of view: i_* are driven into the arbiter and o_* are driven by it.
//
// Modports:
//   slave  - the arbiter itself (takes i_*, drives o_*)
//   master - the surroundings: core ports plus memory map (drive i_*, take o_*)
//
// Signals:
//   i_f_req / i_f_addr / o_f_ack            fetch port handshake
//   i_d_req / i_d_we / i_d_addr / i_d_wdata data port request
//   o_d_ack                                 data port completion pulse
//   o_rdata / o_err                         shared response (valid with ack)
//   o_bus_addr / o_bus_wdata                address/data to memory map
//   o_bus_we / o_bus_re                     bus strobes
//   i_bus_rdata / i_bus_ready               slave response
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  i_f_req;
   logic [ADDR_WIDTH-1:0] i_f_addr;
   logic                  o_f_ack;
   logic                  i_d_req;
   logic                  i_d_we;
   logic [ADDR_WIDTH-1:0] i_d_addr;
   logic [DATA_WIDTH-1:0] i_d_wdata;
   logic                  o_d_ack;
   logic [DATA_WIDTH-1:0] o_rdata;
   logic                  o_err;
   logic [ADDR_WIDTH-1:0] o_bus_addr;
   logic [DATA_WIDTH-1:0] o_bus_wdata;
   logic                  o_bus_we;
   logic                  o_bus_re;
   logic [DATA_WIDTH-1:0] i_bus_rdata;
   logic                  i_bus_ready;

   modport slave (
      input  i_f_req, i_f_addr, i_d_req, i_d_we, i_d_addr, i_d_wdata,
             i_bus_rdata, i_bus_ready,
      output o_f_ack, o_d_ack, o_rdata, o_err,
             o_bus_addr, o_bus_wdata, o_bus_we, o_bus_re
   );

   modport master (
      output i_f_req, i_f_addr, i_d_req, i_d_we, i_d_addr, i_d_wdata,
             i_bus_rdata, i_bus_ready,
      input  o_f_ack, o_d_ack, o_rdata, o_err,
             o_bus_addr, o_bus_wdata, o_bus_we, o_bus_re
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose: shares the single memory-map bus (RAM + UART) between the
// instruction-fetch port and the MEM-stage data port. One transaction at a
// time: IDLE (arbitrate + latch) -> BUSY_F/BUSY_D (strobe until ready) ->
// RESP (one-cycle ack) -> IDLE. Data wins a simultaneous request unless it
// has already won MAX_DATA_STREAK times in a row while fetch was waiting.
// Every output is a register.
//
// Ports:
//   i_clk  - clock, everything on the rising edge
//   i_rst  - synchronous active-high reset
//   port   - mem_port_arbiter_if.slave: requester handshakes, shared
//            response (o_rdata/o_err) and the memory-map bus
//
// Optional feature: define ARB_TIMEOUT_EN to abort a transaction after
// TIMEOUT_CYCLES consecutive cycles without i_bus_ready; the ack then comes
// with o_err = 1 and o_rdata untouched. Without it o_err is always 0 and
// BUSY waits forever.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int MAX_DATA_STREAK = 4,
   parameter int TIMEOUT_CYCLES  = 255
) (
   input  logic               i_clk,
   input  logic               i_rst,
   mem_port_arbiter_if.slave  port
);

   // Refuse to elaborate with a streak limit or timeout below one.
   if (MAX_DATA_STREAK < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("mem_port_arbiter: MAX_DATA_STREAK and TIMEOUT_CYCLES must be >= 1");
   end

   localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_F = 2'd1,
      BUSY_D = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t                state_reg, state_next;
   logic                  grant_f, grant_d;
   logic                  timeout_now;

   logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
   logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
   logic                  we_reg, we_next;
   logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
   logic                  bus_we_reg, bus_we_next;
   logic                  bus_re_reg, bus_re_next;
   logic                  f_ack_reg, f_ack_next;
   logic                  d_ack_reg, d_ack_next;
   logic                  err_reg, err_next;
   logic [STREAK_W-1:0]   streak_reg, streak_next;

   // ------------------------------------------------------------------
   // Optional no-response timeout
   // ------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
   localparam int TIMER_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

   logic [TIMER_W-1:0] timer_reg, timer_next;

   // timer_reg counts the not-ready cycles already seen in this BUSY phase,
   // so the current cycle is the TIMEOUT_CYCLES-th one when it equals LAST.
   always_comb begin
      timer_next = timer_reg;
      if (grant_f || grant_d) begin
         timer_next = '0;
      end else if ((state_reg == BUSY_F || state_reg == BUSY_D) && !port.i_bus_ready) begin
         timer_next = timer_reg + 1'b1;
      end
   end

   assign timeout_now = (state_reg == BUSY_F || state_reg == BUSY_D) &&
                        !port.i_bus_ready && (timer_reg == TIMER_LAST);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         timer_reg <= '0;
      end else begin
         timer_reg <= timer_next;
      end
   end
`else
   assign timeout_now = 1'b0;
`endif

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic and arbitration
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      grant_f    = 1'b0;
      grant_d    = 1'b0;
      case (state_reg)
         IDLE: begin
            // Data has priority until it has starved fetch STREAK_MAX times.
            if (port.i_d_req && (!port.i_f_req || streak_reg != STREAK_MAX)) begin
               grant_d    = 1'b1;
               state_next = BUSY_D;
            end else if (port.i_f_req) begin
               grant_f    = 1'b1;
               state_next = BUSY_F;
            end
         end
         BUSY_F, BUSY_D: begin
            if (port.i_bus_ready || timeout_now) begin
               state_next = RESP;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output logic: next values of the registered outputs, derived from
   // the transition being taken so that strobes and acks appear in the
   // same cycle the FSM enters BUSY/RESP.
   // ------------------------------------------------------------------
   always_comb begin
      addr_next   = addr_reg;
      wdata_next  = wdata_reg;
      we_next     = we_reg;
      rdata_next  = rdata_reg;
      bus_we_next = 1'b0;
      bus_re_next = 1'b0;
      f_ack_next  = 1'b0;
      d_ack_next  = 1'b0;
      err_next    = 1'b0;
      streak_next = streak_reg;

      if (grant_d) begin
         addr_next  = port.i_d_addr;
         wdata_next = port.i_d_wdata;
         we_next    = port.i_d_we;
      end else if (grant_f) begin
         addr_next  = port.i_f_addr;
         we_next    = 1'b0;
      end

      // Only IDLE cycles move the streak: fetch grant or absent fetch
      // clears it, a data grant that makes fetch wait bumps it.
      if (state_reg == IDLE) begin
         if (grant_f || !port.i_f_req) begin
            streak_next = '0;
         end else if (grant_d && streak_reg != STREAK_MAX) begin
            streak_next = streak_reg + 1'b1;
         end
      end

      // Capture read data only on a real completion; a timeout leaves it.
      if (port.i_bus_ready &&
          (state_reg == BUSY_F || (state_reg == BUSY_D && !we_reg))) begin
         rdata_next = port.i_bus_rdata;
      end

      case (state_next)
         BUSY_F: begin
            bus_re_next = 1'b1;
         end
         BUSY_D: begin
            bus_we_next = we_next;
            bus_re_next = ~we_next;
         end
         RESP: begin
            f_ack_next = (state_reg == BUSY_F);
            d_ack_next = (state_reg == BUSY_D);
            err_next   = timeout_now;
         end
         default: begin
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output / datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         addr_reg   <= '0;
         wdata_reg  <= '0;
         we_reg     <= 1'b0;
         rdata_reg  <= '0;
         bus_we_reg <= 1'b0;
         bus_re_reg <= 1'b0;
         f_ack_reg  <= 1'b0;
         d_ack_reg  <= 1'b0;
         err_reg    <= 1'b0;
         streak_reg <= '0;
      end else begin
         addr_reg   <= addr_next;
         wdata_reg  <= wdata_next;
         we_reg     <= we_next;
         rdata_reg  <= rdata_next;
         bus_we_reg <= bus_we_next;
         bus_re_reg <= bus_re_next;
         f_ack_reg  <= f_ack_next;
         d_ack_reg  <= d_ack_next;
         err_reg    <= err_next;
         streak_reg <= streak_next;
      end
   end

   assign port.o_f_ack     = f_ack_reg;
   assign port.o_d_ack     = d_ack_reg;
   assign port.o_rdata     = rdata_reg;
   assign port.o_err       = err_reg;
   assign port.o_bus_addr  = addr_reg;
   assign port.o_bus_wdata = wdata_reg;
   assign port.o_bus_we    = bus_we_reg;
   assign port.o_bus_re    = bus_re_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter (MAX_DATA_STREAK = 4, TIMEOUT_CYCLES = 8).
// Each issued transaction pushes its expected response (port, o_rdata, o_err)
// into a queue; a monitor pops and compares on every ack pulse. Timing and
// strobe checks are made inline by the stimulus. A negedge-driven slave model
// asserts i_bus_ready after a programmable number of wait states and returns
// {addr[15:0], 16'hC0DE} unless a fixed value is selected.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

   mem_port_arbiter #(
      .DATA_WIDTH      (32),
      .ADDR_WIDTH      (32),
      .MAX_DATA_STREAK (4),
      .TIMEOUT_CYCLES  (8)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .port  (bus.slave)
   );

   typedef struct {
      bit          is_f;
      logic [31:0] rdata;
      bit          err;
   } exp_t;

   exp_t exp_q[$];
   int   vec_count   = 0;
   int   miscompares = 0;

   // ---------------- slave model ----------------
   int          slave_waits = 0;
   int          slave_cnt   = 0;
   bit          use_fixed   = 1'b0;
   logic [31:0] fixed_rdata = 32'h0;

   always @(negedge clk) begin
      if (bus.o_bus_re || bus.o_bus_we) begin
         bus.i_bus_ready = (slave_cnt == slave_waits);
         bus.i_bus_rdata = use_fixed ? fixed_rdata : {bus.o_bus_addr[15:0], 16'hC0DE};
         slave_cnt       = slave_cnt + 1;
      end else begin
         bus.i_bus_ready = 1'b0;
         bus.i_bus_rdata = 32'hBAD0_BAD0;
         slave_cnt       = 0;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   bit prev_ack = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (bus.o_f_ack || bus.o_d_ack) begin
         vec_count++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_ack: f_ack=%b d_ack=%b rdata=%h, no transaction outstanding",
                     bus.o_f_ack, bus.o_d_ack, bus.o_rdata);
         end else begin
            e = exp_q.pop_front();
            if ((bus.o_f_ack && bus.o_d_ack) || (bus.o_f_ack != e.is_f) ||
                (bus.o_rdata !== e.rdata) || (bus.o_err !== e.err) || prev_ack) begin
               miscompares++;
               $display("FAIL ack_response: got f_ack=%b d_ack=%b rdata=%h err=%b prev_ack=%b, expected %s rdata=%h err=%b single pulse",
                        bus.o_f_ack, bus.o_d_ack, bus.o_rdata, bus.o_err, prev_ack,
                        e.is_f ? "fetch" : "data", e.rdata, e.err);
            end else begin
               $display("ok   ack %s rdata=%h err=%b", e.is_f ? "fetch" : "data", bus.o_rdata, bus.o_err);
            end
         end
      end
      prev_ack = bus.o_f_ack || bus.o_d_ack;
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_count++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic chk_bit(input string name, input logic act, input logic exp);
      vec_count++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end else begin
         $display("ok   %s: %b", name, act);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      vec_count++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   function automatic exp_t mk_exp(input bit is_f, input logic [31:0] rdata, input bit err);
      exp_t e;
      e.is_f  = is_f;
      e.rdata = rdata;
      e.err   = err;
      return e;
   endfunction

   // Counts negedges from the request cycle (that negedge counts as 1) up to
   // and including the ack; an expired budget is itself a failure.
   task automatic wait_ack(input bit is_f, input int budget, output int n);
      logic seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < budget) begin
         @(negedge clk);
         n++;
         seen = is_f ? bus.o_f_ack : bus.o_d_ack;
      end
      if (!seen) begin
         vec_count++;
         miscompares++;
         $display("FAIL ack_wait: no %s ack within %0d cycles", is_f ? "fetch" : "data", budget);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk_bit({tag, "_bus_re"}, bus.o_bus_re, 1'b0);
      chk_bit({tag, "_bus_we"}, bus.o_bus_we, 1'b0);
      chk_bit({tag, "_f_ack"},  bus.o_f_ack,  1'b0);
      chk_bit({tag, "_d_ack"},  bus.o_d_ack,  1'b0);
      chk_bit({tag, "_err"},    bus.o_err,    1'b0);
      chk({tag, "_rdata"},      bus.o_rdata,     32'h0);
      chk({tag, "_bus_addr"},   bus.o_bus_addr,  32'h0);
      chk({tag, "_bus_wdata"},  bus.o_bus_wdata, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int acks;
      int errs;

      rst           = 1'b1;
      bus.i_f_req   = 1'b0;
      bus.i_f_addr  = 32'h0;
      bus.i_d_req   = 1'b0;
      bus.i_d_we    = 1'b0;
      bus.i_d_addr  = 32'h0;
      bus.i_d_wdata = 32'h0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // ---- T1: single fetch, zero wait states ----
      use_fixed   = 1'b1;
      fixed_rdata = 32'h00A0_0093;
      slave_waits = 0;
      exp_q.push_back(mk_exp(1'b1, 32'h00A0_0093, 1'b0));
      @(posedge clk); #1;
      bus.i_f_req  = 1'b1;
      bus.i_f_addr = 32'h0000_0010;
      @(negedge clk);
      chk_bit("t1_re_c0", bus.o_bus_re, 1'b0);
      @(negedge clk);
      chk_bit("t1_re_c1", bus.o_bus_re, 1'b1);
      chk("t1_addr_c1", bus.o_bus_addr, 32'h0000_0010);
      @(negedge clk);
      chk_bit("t1_re_c2", bus.o_bus_re, 1'b0);
      chk_bit("t1_f_ack_c2", bus.o_f_ack, 1'b1);
      @(posedge clk); #1;
      bus.i_f_req = 1'b0;
      use_fixed   = 1'b0;
      repeat (2) @(posedge clk);

      // ---- T2: data write, three wait states ----
      slave_waits = 3;
      exp_q.push_back(mk_exp(1'b0, 32'h00A0_0093, 1'b0));
      @(posedge clk); #1;
      bus.i_d_req   = 1'b1;
      bus.i_d_we    = 1'b1;
      bus.i_d_addr  = 32'h1001_0000;
      bus.i_d_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         chk_bit($sformatf("t2_we_c%0d", c), bus.o_bus_we, 1'b1);
         chk_bit($sformatf("t2_re_c%0d", c), bus.o_bus_re, 1'b0);
         chk($sformatf("t2_addr_c%0d", c), bus.o_bus_addr, 32'h1001_0000);
         chk($sformatf("t2_wdata_c%0d", c), bus.o_bus_wdata, 32'hDEAD_BEEF);
      end
      @(negedge clk);
      chk_bit("t2_we_c5", bus.o_bus_we, 1'b0);
      chk_bit("t2_d_ack_c5", bus.o_d_ack, 1'b1);
      @(posedge clk); #1;
      bus.i_d_req = 1'b0;
      bus.i_d_we  = 1'b0;
      repeat (2) @(posedge clk);

      // ---- T3: both held high, expect D,D,D,D,F,D,D,D,D,F ----
      slave_waits = 0;
      for (int k = 0; k < 10; k++) begin
         if (k == 4 || k == 9) exp_q.push_back(mk_exp(1'b1, 32'h0100_C0DE, 1'b0));
         else                  exp_q.push_back(mk_exp(1'b0, 32'h2000_C0DE, 1'b0));
      end
      @(posedge clk); #1;
      bus.i_f_req  = 1'b1;
      bus.i_f_addr = 32'h0000_0100;
      bus.i_d_req  = 1'b1;
      bus.i_d_we   = 1'b0;
      bus.i_d_addr = 32'h0000_2000;
      acks = 0;
      n    = 0;
      while (acks < 10 && n < 200) begin
         @(negedge clk);
         n++;
         if (bus.o_f_ack || bus.o_d_ack) acks++;
      end
      chk_int("t3_ack_count", acks, 10);
      chk_int("t3_total_cycles", n, 30);
      @(posedge clk); #1;
      bus.i_f_req = 1'b0;
      bus.i_d_req = 1'b0;
      repeat (2) @(posedge clk);

      // ---- T4: fetch in flight, data arrives during BUSY_F ----
      slave_waits = 2;
      exp_q.push_back(mk_exp(1'b1, 32'h0300_C0DE, 1'b0));
      exp_q.push_back(mk_exp(1'b0, 32'h4000_C0DE, 1'b0));
      @(posedge clk); #1;
      bus.i_f_req  = 1'b1;
      bus.i_f_addr = 32'h0000_0300;
      @(posedge clk); #1;
      bus.i_d_req  = 1'b1;
      bus.i_d_we   = 1'b0;
      bus.i_d_addr = 32'h0000_4000;
      bus.i_f_addr = 32'h0000_0999;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         chk($sformatf("t4_f_addr_c%0d", c), bus.o_bus_addr, 32'h0000_0300);
         chk_bit($sformatf("t4_f_re_c%0d", c), bus.o_bus_re, 1'b1);
      end
      @(negedge clk);
      chk_bit("t4_f_ack_c4", bus.o_f_ack, 1'b1);
      chk_bit("t4_no_d_ack_c4", bus.o_d_ack, 1'b0);
      @(posedge clk); #1;
      bus.i_f_req = 1'b0;
      @(negedge clk);
      chk_bit("t4_idle_re_c5", bus.o_bus_re, 1'b0);
      @(negedge clk);
      chk("t4_d_addr_c6", bus.o_bus_addr, 32'h0000_4000);
      chk_bit("t4_d_re_c6", bus.o_bus_re, 1'b1);
      wait_ack(1'b0, 20, n);
      chk_int("t4_d_ack_latency", n, 3);
      @(posedge clk); #1;
      bus.i_d_req = 1'b0;
      repeat (2) @(posedge clk);

      // ---- T5: reset during a waiting data read ----
      slave_waits = 50;
      @(posedge clk); #1;
      bus.i_d_req  = 1'b1;
      bus.i_d_we   = 1'b0;
      bus.i_d_addr = 32'h0000_5000;
      @(posedge clk); #1;
      @(negedge clk);
      chk_bit("t5_re_c1", bus.o_bus_re, 1'b1);
      @(posedge clk); #1;
      rst         = 1'b1;
      bus.i_d_req = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check_all_zero("t5_after_rst");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);

      slave_waits = 0;
      exp_q.push_back(mk_exp(1'b1, 32'h0020_C0DE, 1'b0));
      @(posedge clk); #1;
      bus.i_f_req  = 1'b1;
      bus.i_f_addr = 32'h0000_0020;
      wait_ack(1'b1, 20, n);
      chk_int("t5_fetch_latency", n, 3);
      @(posedge clk); #1;
      bus.i_f_req = 1'b0;
      repeat (2) @(posedge clk);

      // ---- T6: slave never ready ----
      slave_waits = 100000;
`ifdef ARB_TIMEOUT_EN
      exp_q.push_back(mk_exp(1'b0, 32'h0020_C0DE, 1'b1));
      @(posedge clk); #1;
      bus.i_d_req  = 1'b1;
      bus.i_d_we   = 1'b0;
      bus.i_d_addr = 32'h0000_6000;
      wait_ack(1'b0, 30, n);
      chk_int("t6_timeout_latency", n, 10);
      @(posedge clk); #1;
      bus.i_d_req = 1'b0;
      repeat (2) @(posedge clk);
`else
      @(posedge clk); #1;
      bus.i_d_req  = 1'b1;
      bus.i_d_we   = 1'b0;
      bus.i_d_addr = 32'h0000_6000;
      acks = 0;
      errs = 0;
      repeat (100) begin
         @(negedge clk);
         if (bus.o_f_ack || bus.o_d_ack) acks++;
         if (bus.o_err) errs++;
      end
      chk_int("t6_no_ack_100", acks, 0);
      chk_int("t6_no_err_100", errs, 0);
      chk_bit("t6_still_busy_re", bus.o_bus_re, 1'b1);
      @(posedge clk); #1;
      rst         = 1'b1;
      bus.i_d_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
`endif

      repeat (3) @(posedge clk);
      chk_int("queue_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter that shares the single memory-map bus (RAM + UART slaves) between the instruction-fetch port and the data (MEM-stage) port of the pipelined RISC-V core. It runs one transaction at a time and sequences each one through a request/ack handshake. It absorbs slave wait states and uses a bounded-priority policy: data wins by default, and fetch is guaranteed progress. Optionally, it aborts transactions to slaves that stop responding.

## Interface
- DATA_WIDTH, 32, bus data width
- ADDR_WIDTH, 32, bus address width
- MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch waits (≥1)
- TIMEOUT_CYCLES, 255, bus cycles without ready before abort (≥1; used only with ARB_TIMEOUT_EN)

- i_clk  input  1  single clock, all logic on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_f_req  input  1  fetch request, held until o_f_ack
- i_f_addr  input  ADDR_WIDTH  fetch address, stable while i_f_req
- o_f_ack  output  1  one-cycle completion pulse for fetch
- i_d_req  input  1  data request, held until o_d_ack
- i_d_we  input  1  1 = write, 0 = read
- i_d_addr  input  ADDR_WIDTH  data address
- i_d_wdata  input  DATA_WIDTH  write data
- o_d_ack  output  1  one-cycle completion pulse for data
- o_rdata  output  DATA_WIDTH  read data, valid during the ack cycle
- o_err  output  1  pulses with ack when the transaction timed out
- o_bus_addr  output  ADDR_WIDTH  to memory map
- o_bus_wdata  output  DATA_WIDTH  to memory map
- o_bus_we  output  1  bus write strobe
- o_bus_re  output  1  bus read strobe
- i_bus_rdata  input  DATA_WIDTH  from memory map
- i_bus_ready  input  1  slave completes the current access this cycle

## Operation
- FSM states: IDLE, BUSY_F, BUSY_D, RESP. Reset state is IDLE.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant data unless streak == MAX_DATA_STREAK, in which case grant fetch.
  - On grant, latch the address, wdata and we, then go to BUSY_F or BUSY_D.
- Streak counter:
  - Increments on a data grant while i_f_req is high.
  - Clears on any fetch grant and on any IDLE cycle with i_f_req low.
  - Saturates at MAX_DATA_STREAK.
- BUSY_x:
  - Drive the latched address and wdata.
  - Fetch: o_bus_re = 1. Data: o_bus_we = we, o_bus_re = ~we.
  - On i_bus_ready = 1, register i_bus_rdata into o_rdata, then go to RESP.
- RESP:
  - Pulse the granted port's ack for one cycle; o_bus_re and o_bus_we are 0.
  - Both requests are ignored in this cycle; next state is IDLE.
- Requesters drop req in the cycle after ack. A req still high when IDLE is re-entered starts a new transaction.
- Changes to req, addr or wdata while that port is in BUSY are ignored, because the values were latched at grant.
- o_rdata holds its value until the next read completes. For writes, o_rdata is unchanged.
- Reset mid-transaction: the next state is IDLE and the bus strobes drop in the cycle after the reset edge. The slave transaction is abandoned and no ack is issued.
- Reset values:
  - o_f_ack, o_d_ack, o_err, o_bus_we, o_bus_re = 0.
  - o_bus_addr, o_bus_wdata, o_rdata = 0.
  - Streak counter = 0; timeout counter = 0.

## Timing
- All outputs are registered.
- Minimum latency: req sampled at edge 0, bus strobe high in cycle 1, i_bus_ready in cycle 1, ack in cycle 2.
- Each slave wait state adds one cycle.
- Back-to-back rate is at most one transaction per 3 cycles (IDLE → BUSY → RESP).
- Both requests rising on the same edge: data is served first and fetch is acked at the earliest 3 cycles after data's ack.
- Fetch worst-case wait with zero-wait-state slaves is MAX_DATA_STREAK × 3 + 3 cycles.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8+ bit counter runs in BUSY_x.
  - After TIMEOUT_CYCLES consecutive cycles with i_bus_ready = 0, the FSM goes to RESP, pulses ack together with o_err = 1, and leaves o_rdata unchanged.
  - The counter clears on every grant.
- ARB_TIMEOUT_EN undefined:
  - No counter is implemented; BUSY_x waits indefinitely.
  - o_err is tied to 0.

## Test plan
- Single fetch, addr 0x0000_0010, ready immediate, bus rdata 0x00A0_0093 → o_bus_re high in cycle 1 only; o_f_ack and o_rdata = 0x00A0_0093 in cycle 2.
- Data write to 0x1001_0000, wdata 0xDEAD_BEEF, ready after 3 wait states → o_bus_we high for 4 cycles with the address and data stable; o_d_ack in cycle 5; o_rdata unchanged.
- Both req held high continuously, MAX_DATA_STREAK = 4, zero wait states → grant order D,D,D,D,F,D,D,D,D,F; each ack is a single-cycle pulse.
- Fetch req only, then d_req raised during BUSY_F → fetch completes first, data is granted on the IDLE cycle after RESP, and the fetch address is not disturbed.
- i_rst asserted in cycle 2 of a waiting data read → strobes low next cycle, no ack, all outputs 0; a fresh fetch afterwards completes normally.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, i_bus_ready held 0 → o_d_ack and o_err pulse together on the 9th cycle after grant; without the macro, the FSM stays in BUSY_D for 100 cycles and o_err remains 0.
